// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared floating-point definitions for the RV32F FPU blocks.
//                Holds the exponent bias, the canonical quiet NaN, the fflags
//                bit positions, the divider state encoding and the operand
//                classification type.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int          EXP_BIAS   = 127;
    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

    // fflags = {NV, DZ, OF, UF, NX}
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        DIV  = 3'd2,
        NORM = 3'd3,
        PACK = 3'd4
    } fdiv_state_t;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        NORMAL = 3'd1,
        INF    = 3'd2,
        QNAN   = 3'd3,
        SNAN   = 3'd4
    } fp_class_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fdiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : fdiv_seq_if
//  Description : Request/response bundle of the iterative FP divider.
//                master : drives start, a, b; observes busy, done, result, flags
//                slave  : the divider side
//  Revision    : 1.0  initial release
// ============================================================================
interface fdiv_seq_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] result;
    logic [4:0]        flags;

    modport master (output start, a, b, input busy, done, result, flags);
    modport slave  (input start, a, b, output busy, done, result, flags);
endinterface : fdiv_seq_if
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_classify
//  Description : Combinational unpack of one IEEE-754 word into class, sign,
//                biased exponent and mantissa with the hidden bit restored.
//                Subnormals are flushed: they classify as ZERO with a zero
//                mantissa.
//  Ports       : i_word  packed operand
//                o_cls   ZERO / NORMAL / INF / QNAN / SNAN
//                o_sign  sign bit
//                o_exp   biased exponent field
//                o_man   {hidden, fraction}
//  Revision    : 1.0  initial release
// ============================================================================
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] i_word,
    output fp_class_t            o_cls,
    output logic                 o_sign,
    output logic [EXP_W-1:0]     o_exp,
    output logic [MAN_W:0]       o_man
);

    logic [MAN_W-1:0] w_frac;

    always_comb begin
        o_sign = i_word[EXP_W+MAN_W];
        o_exp  = i_word[EXP_W+MAN_W-1:MAN_W];
        w_frac = i_word[MAN_W-1:0];
        o_man  = {1'b1, w_frac};
        o_cls  = NORMAL;
        if (o_exp == '0) begin
            o_cls = ZERO;
            o_man = '0;
        end else if (&o_exp) begin
            o_man = {1'b0, w_frac};
            if (w_frac == '0)
                o_cls = INF;
            else if (w_frac[MAN_W-1])
                o_cls = QNAN;
            else
                o_cls = SNAN;
        end
    end

endmodule : fp_classify
`default_nettype wire

// File: rtl/fdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fdiv_seq
//  Description : Iterative IEEE-754 single-precision divider (a / b), radix-2
//                restoring mantissa divide, fixed latency of MAN_W+6 cycles
//                from the accepting edge to the done pulse, RV32F fflags.
//  Ports       : clk, rst (synchronous, active high)
//                bus.start/a/b      request, operands latched on accept
//                bus.busy           high while an operation is in flight
//                bus.done           one-cycle completion pulse
//                bus.result/flags   quotient and {NV,DZ,OF,UF,NX}, held
//  Config      : FDIV_RNE_EN defined   -> round to nearest even
//                FDIV_RNE_EN undefined -> truncate (round toward zero)
//  Revision    : 1.0  initial release
// ============================================================================
module fdiv_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic      clk,
    input  logic      rst,
    fdiv_seq_if.slave bus
);

    localparam int c_word_w = 1 + EXP_W + MAN_W;
    localparam int c_cnt_w  = $clog2(MAN_W + 3);
    localparam logic [c_cnt_w-1:0]      c_last    = c_cnt_w'(MAN_W + 2);
    localparam logic signed [EXP_W+1:0] c_bias    = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EXP_W+1:0] c_exp_max = (EXP_W+2)'((1 << EXP_W) - 1);

    fdiv_state_t r_state, w_state_nxt;

    logic [c_word_w-1:0]      r_a, r_b;
    logic                     r_sign;
    logic signed [EXP_W+1:0]  r_exp;
    logic [MAN_W+1:0]         r_rem;
    logic [MAN_W:0]           r_div;
    logic [MAN_W+2:0]         r_q;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [MAN_W-1:0]         r_frac;
    logic                     r_grd, r_rnd, r_stk;
    logic                     r_spec;
    logic [c_word_w-1:0]      r_spec_res;
    logic [4:0]               r_spec_flags;
    logic                     r_done;
    logic [c_word_w-1:0]      r_result;
    logic [4:0]               r_flags;

    fp_class_t                w_cls_a, w_cls_b;
    logic                     w_sign_a, w_sign_b;
    logic [EXP_W-1:0]         w_exp_a, w_exp_b;
    logic [MAN_W:0]           w_man_a, w_man_b;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .i_word (r_a), .o_cls (w_cls_a), .o_sign (w_sign_a), .o_exp (w_exp_a), .o_man (w_man_a)
    );
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .i_word (r_b), .o_cls (w_cls_b), .o_sign (w_sign_b), .o_exp (w_exp_b), .o_man (w_man_b)
    );

    // ---------------------------------------------------------------- PREP
    logic                     w_sign;
    logic signed [EXP_W+1:0]  w_exp_pre;
    logic                     w_spec;
    logic [c_word_w-1:0]      w_spec_res;
    logic [4:0]               w_spec_flags;

    always_comb begin
        w_sign       = w_sign_a ^ w_sign_b;
        w_exp_pre    = signed'({2'b00, w_exp_a}) - signed'({2'b00, w_exp_b}) + c_bias;
        w_spec       = 1'b1;
        w_spec_res   = CANON_QNAN;
        w_spec_flags = '0;
        if (w_cls_a inside {QNAN, SNAN} || w_cls_b inside {QNAN, SNAN}) begin
            w_spec_flags[FLAG_NV] = (w_cls_a == SNAN) || (w_cls_b == SNAN);
        end else if ((w_cls_a == INF && w_cls_b == INF) ||
                     (w_cls_a == ZERO && w_cls_b == ZERO)) begin
            w_spec_flags[FLAG_NV] = 1'b1;
        end else if (w_cls_b == ZERO) begin
            w_spec_res            = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_spec_flags[FLAG_DZ] = 1'b1;
        end else if (w_cls_a == INF) begin
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_cls_b == INF || w_cls_a == ZERO) begin
            w_spec_res = {w_sign, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    // ----------------------------------------------------------------- DIV
    logic             w_ge;
    logic [MAN_W+1:0] w_sub;

    always_comb begin
        w_ge  = (r_rem >= {1'b0, r_div});
        w_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
    end

    // ---------------------------------------------------------------- PACK
    logic                     w_inc, w_carry, w_nx;
    logic [MAN_W-1:0]         w_frac_rnd;
    logic signed [EXP_W+1:0]  w_exp_rnd;
    logic [c_word_w-1:0]      w_pack_res;
    logic [4:0]               w_pack_flags;

    always_comb begin
        w_nx = r_grd | r_rnd | r_stk;
`ifdef FDIV_RNE_EN
        w_inc = r_grd & (r_rnd | r_stk | r_frac[0]);
`else
        w_inc = 1'b0;
`endif
        // An all-ones fraction wraps to zero on increment; that carry bumps the exponent.
        w_frac_rnd   = r_frac + {{(MAN_W-1){1'b0}}, w_inc};
        w_carry      = w_inc & (&r_frac);
        w_exp_rnd    = r_exp + {{(EXP_W+1){1'b0}}, w_carry};
        w_pack_res   = {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
        w_pack_flags = '0;
        w_pack_flags[FLAG_NX] = w_nx;
        if (r_spec) begin
            w_pack_res   = r_spec_res;
            w_pack_flags = r_spec_flags;
        end else if (w_exp_rnd >= c_exp_max) begin
            w_pack_res            = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_pack_flags[FLAG_OF] = 1'b1;
            w_pack_flags[FLAG_NX] = 1'b1;
        end else if (w_exp_rnd[EXP_W+1] || (w_exp_rnd == '0)) begin
            w_pack_res            = {r_sign, {(EXP_W+MAN_W){1'b0}}};
            w_pack_flags[FLAG_UF] = 1'b1;
            w_pack_flags[FLAG_NX] = 1'b1;
        end
    end

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = PREP;
            PREP:    w_state_nxt = DIV;
            DIV:     if (r_cnt == c_last) w_state_nxt = NORM;
            NORM:    w_state_nxt = PACK;
            PACK:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0; r_b <= '0; r_sign <= 1'b0; r_exp <= '0;
            r_rem <= '0; r_div <= '0; r_q <= '0; r_cnt <= '0;
            r_frac <= '0; r_grd <= 1'b0; r_rnd <= 1'b0; r_stk <= 1'b0;
            r_spec <= 1'b0; r_spec_res <= '0; r_spec_flags <= '0;
            r_done <= 1'b0; r_result <= '0; r_flags <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a <= bus.a;
                        r_b <= bus.b;
                    end
                end
                PREP: begin
                    r_sign       <= w_sign;
                    r_exp        <= w_exp_pre;
                    r_rem        <= {1'b0, w_man_a};
                    r_div        <= w_man_b;
                    r_q          <= '0;
                    r_cnt        <= '0;
                    r_spec       <= w_spec;
                    r_spec_res   <= w_spec_res;
                    r_spec_flags <= w_spec_flags;
                end
                DIV: begin
                    r_q   <= {r_q[MAN_W+1:0], w_ge};
                    r_rem <= w_sub << 1;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
                NORM: begin
                    r_stk <= (r_rem != '0);
                    if (r_q[MAN_W+2]) begin
                        r_frac <= r_q[MAN_W+1:2];
                        r_grd  <= r_q[1];
                        r_rnd  <= r_q[0];
                    end else begin
                        r_frac <= r_q[MAN_W:1];
                        r_grd  <= r_q[0];
                        r_rnd  <= 1'b0;
                        r_exp  <= r_exp - (EXP_W+2)'(1);
                    end
                end
                PACK: begin
                    r_result <= w_pack_res;
                    r_flags  <= w_pack_flags;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.flags  = r_flags;

endmodule : fdiv_seq
`default_nettype wire

// File: tb/tb_fdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fdiv_seq
//  Description : Self-checking bench for fdiv_seq: directed spec vectors,
//                handshake corner cases, reset abort and randomized operands
//                against an integer-arithmetic reference quotient.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fdiv_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fdiv_seq_if bus ();
    fdiv_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

`ifdef FDIV_RNE_EN
    localparam logic [31:0] c_third = 32'h3EAA_AAAB;
`else
    localparam logic [31:0] c_third = 32'h3EAA_AAAA;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer quotient of the 24-bit significands, then the
    // rounding/flag rules applied to that value.
    function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        sa, sb, s, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, z_a, z_b;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        longint      n, d, q, rm;
        logic [25:0] qv;
        logic [24:0] m;
        logic        g, r, st, inc, nx;
        int          e;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        s = sa ^ sb;
        nan_a = (ea == 8'hFF) && (fa != 0); snan_a = nan_a && !fa[22];
        nan_b = (eb == 8'hFF) && (fb != 0); snan_b = nan_b && !fb[22];
        inf_a = (ea == 8'hFF) && (fa == 0); inf_b = (eb == 8'hFF) && (fb == 0);
        z_a = (ea == 0); z_b = (eb == 0);
        if (nan_a || nan_b)                return {32'h7FC00000, (snan_a || snan_b), 4'b0};
        if ((inf_a && inf_b) || (z_a && z_b)) return {32'h7FC00000, 5'b10000};
        if (z_b)                           return {s, 8'hFF, 23'd0, 5'b01000};
        if (inf_a)                         return {s, 8'hFF, 23'd0, 5'b00000};
        if (inf_b || z_a)                  return {s, 31'd0, 5'b00000};
        n  = longint'({1'b1, fa}) << 25;
        d  = longint'({1'b1, fb});
        q  = n / d;
        rm = n % d;
        qv = q[25:0];
        e  = int'(ea) - int'(eb) + 127;
        if (qv[25]) begin
            m = {1'b0, qv[25:2]}; g = qv[1]; r = qv[0];
        end else begin
            m = {1'b0, qv[24:1]}; g = qv[0]; r = 1'b0; e = e - 1;
        end
        st = (rm != 0);
        nx = g | r | st;
`ifdef FDIV_RNE_EN
        inc = g & (r | st | m[0]);
`else
        inc = 1'b0;
`endif
        m = m + {24'd0, inc};
        if (m[24]) e = e + 1;
        if (e >= 255) return {s, 8'hFF, 23'd0, 5'b00101};
        if (e <= 0)   return {s, 31'd0, 5'b00011};
        return {s, 8'(e), m[22:0], 4'b0, nx};
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1:    return $urandom;
            2: begin
                case ($urandom_range(0, 5))
                    0:       return 32'h0000_0000;
                    1:       return 32'h7F80_0000;
                    2:       return 32'h7FC0_1234;
                    3:       return 32'h7F80_0001;
                    4:       return 32'h0000_5555;
                    default: return 32'h8000_0000;
                endcase
            end
            default: return {1'($urandom), 8'($urandom_range(60, 194)), 23'($urandom)};
        endcase
    endfunction

    // Drive a request; returns #1 after the accepting edge with operands scrambled.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v);
        bus.start = 1'b1; bus.a = ta; bus.b = tb_v;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    endtask

    // Counts edges from the accept edge to done; optional start pokes while busy.
    task automatic wait_done(input string tag, input logic [31:0] er, input logic [4:0] ef,
                             input bit poke);
        int lat, bad;
        lat = 0; bad = 0;
        while (lat < 40) begin
            lat++;
            @(posedge clk); #1;
            if (bus.done) break;
            if (!bus.busy) bad++;
            bus.start = poke && (lat == 5 || lat == 12 || lat == 28);
            bus.a = $urandom; bus.b = $urandom;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, lat, 29);
        check({tag, " busy"}, bad, 0);
        check({tag, " busy@done"}, {31'd0, bus.busy}, 0);
        check({tag, " result"}, bus.result, er);
        check({tag, " flags"}, {27'd0, bus.flags}, {27'd0, ef});
    endtask

    task automatic run_dir(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic [31:0] er, input logic [4:0] ef);
        @(negedge clk);
        issue(ta, tb_v);
        wait_done(tag, er, ef, 1'b0);
        @(posedge clk); #1;
        check({tag, " done pulse"}, {31'd0, bus.done}, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [36:0] ex;
        int n_done;

        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   {31'd0, bus.busy}, 0);
        check("reset done",   {31'd0, bus.done}, 0);
        check("reset result", bus.result, 0);
        check("reset flags",  {27'd0, bus.flags}, 0);
        rst = 1'b0;

        run_dir("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        run_dir("1/3",      32'h3F800000, 32'h40400000, c_third,      5'b00001);
        run_dir("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000);
        run_dir("0/0",      32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000);
        run_dir("snan/1",   32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000);
        run_dir("-1/inf",   32'hBF800000, 32'h7F800000, 32'h80000000, 5'b00000);
        run_dir("overflow", 32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 5'b00101);
        run_dir("underflow",32'h00800000, 32'h7F7FFFFF, 32'h00000000, 5'b00011);

        // Back-to-back: second request raised in the done cycle.
        @(negedge clk);
        issue(32'h40C00000, 32'h40000000);
        wait_done("b2b first", 32'h40400000, 5'b00000, 1'b0);
        issue(32'h3F800000, 32'h40400000);
        wait_done("b2b second", c_third, 5'b00001, 1'b0);

        // start pulses while busy must be ignored.
        @(negedge clk);
        issue(32'h40C00000, 32'h40000000);
        wait_done("poke", 32'h40400000, 5'b00000, 1'b1);
        n_done = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("poke extra done", n_done, 0);

        // Reset at edge 10 of an operation.
        @(negedge clk);
        issue(32'h3F800000, 32'h40400000);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy",   {31'd0, bus.busy}, 0);
        check("abort done",   {31'd0, bus.done}, 0);
        check("abort result", bus.result, 0);
        check("abort flags",  {27'd0, bus.flags}, 0);
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("abort no done", n_done, 0);
        run_dir("after abort", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);

        // Randomized operands against the reference quotient.
        for (int i = 0; i < 30; i++) begin
            ra = rand_op();
            rb = rand_op();
            ex = ref_div(ra, rb);
            run_dir($sformatf("rand%0d %h/%h", i, ra, rb), ra, rb, ex[36:5], ex[4:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fdiv_seq
`default_nettype wire
